// File: rtl/proxy_fifo_bridge.sv
// Driver-to-proxy FIFO bridge: first-word fall-through buffer with either
// backpressure or drop-on-full admission, plus transfer and drop counters.
module proxy_fifo_bridge #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DROP_MODE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        driver_data,
  input  logic                     driver_valid,
  output logic                     driver_ready,
  output logic [DATA_W-1:0]        proxy_data,
  output logic                     proxy_valid,
  input  logic                     proxy_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         xfer_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic full, push, pop, drop;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot.
  assign full         = (level_q == LW'(DEPTH));
  assign driver_ready = (DROP_MODE != 0) ? 1'b1 : (!full && !flush);
  assign proxy_valid  = (level_q != '0);
  assign proxy_data   = proxy_valid ? mem_q[rd_ptr_q] : '0;
  assign level        = level_q;
  assign xfer_cnt     = xfer_q;
  assign drop_cnt     = drop_q;

  assign push = driver_valid && driver_ready && !flush && !full;
  assign pop  = proxy_valid && proxy_ready;
  assign drop = (DROP_MODE != 0) && driver_valid && (full || flush);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    xfer_d   = xfer_q;
    drop_d   = drop_q;

    if (pop) xfer_d = xfer_q + CNT_W'(1);
    if (drop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Power-of-two depth: pointer wrap falls out of natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      xfer_q   <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      xfer_q   <= xfer_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= driver_data;
  end

endmodule

// File: tb/tb_proxy_fifo_bridge.sv
// Bench for proxy_fifo_bridge: backpressure, drop, and narrow-counter instances
// driven by shared stimulus and checked against queue-based reference models.
module tb_proxy_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv, pr, fl;
  logic [7:0] dd;

  logic       dr0, dr1, dr2, pv0, pv1, pv2;
  logic [7:0] pd0, pd1, pd2;
  logic [2:0] lv0, lv1, lv2;
  logic [15:0] xc0, xc1, dc0, dc1;
  logic [2:0]  xc2, dc2;

  logic        dr [3];
  logic        pv [3];
  logic [7:0]  pd [3];
  logic [2:0]  lv [3];
  logic [15:0] xc [3];
  logic [15:0] dc [3];

  always #5 clk = ~clk;

  proxy_fifo_bridge #(.DATA_W(8), .DEPTH(4), .DROP_MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .driver_data(dd), .driver_valid(dv), .driver_ready(dr0),
    .proxy_data(pd0), .proxy_valid(pv0), .proxy_ready(pr), .flush(fl),
    .level(lv0), .xfer_cnt(xc0), .drop_cnt(dc0));

  proxy_fifo_bridge #(.DATA_W(8), .DEPTH(4), .DROP_MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .driver_data(dd), .driver_valid(dv), .driver_ready(dr1),
    .proxy_data(pd1), .proxy_valid(pv1), .proxy_ready(pr), .flush(fl),
    .level(lv1), .xfer_cnt(xc1), .drop_cnt(dc1));

  proxy_fifo_bridge #(.DATA_W(8), .DEPTH(4), .DROP_MODE(1), .CNT_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .driver_data(dd), .driver_valid(dv), .driver_ready(dr2),
    .proxy_data(pd2), .proxy_valid(pv2), .proxy_ready(pr), .flush(fl),
    .level(lv2), .xfer_cnt(xc2), .drop_cnt(dc2));

  always_comb begin
    dr[0] = dr0; dr[1] = dr1; dr[2] = dr2;
    pv[0] = pv0; pv[1] = pv1; pv[2] = pv2;
    pd[0] = pd0; pd[1] = pd1; pd[2] = pd2;
    lv[0] = lv0; lv[1] = lv1; lv[2] = lv2;
    xc[0] = xc0; xc[1] = xc1; xc[2] = {13'd0, xc2};
    dc[0] = dc0; dc[1] = dc1; dc[2] = {13'd0, dc2};
  end

  // Reference model: one queue per instance plus raw (unwrapped) event counts.
  logic [7:0]  mq [3][$];
  int unsigned nx [3];
  int unsigned nd [3];
  int unsigned mode [3] = '{0, 1, 1};
  int unsigned cw   [3] = '{16, 16, 3};

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      nx[i] = 0;
      nd[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      int unsigned sz   = mq[i].size();
      int unsigned mask = (32'd1 << cw[i]) - 1;
      logic [7:0]  epd  = (sz != 0) ? mq[i][0] : 8'h00;
      logic        edr  = (mode[i] != 0) ? 1'b1 : ((sz < 4) && !fl);
      check($sformatf("%s.u%0d.level", tag, i), 32'(lv[i]), sz);
      check($sformatf("%s.u%0d.proxy_valid", tag, i), 32'(pv[i]), 32'(sz != 0));
      check($sformatf("%s.u%0d.proxy_data", tag, i), 32'(pd[i]), 32'(epd));
      check($sformatf("%s.u%0d.driver_ready", tag, i), 32'(dr[i]), 32'(edr));
      check($sformatf("%s.u%0d.xfer_cnt", tag, i), 32'(xc[i]), nx[i] & mask);
      check($sformatf("%s.u%0d.drop_cnt", tag, i), 32'(dc[i]), (nd[i] > mask) ? mask : nd[i]);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int unsigned sz = mq[i].size();
      bit full = (sz == 4);
      bit rdy  = (mode[i] != 0) || (!full && !fl);
      bit pop  = (sz != 0) && pr;
      bit push = dv && rdy && !fl && !full;
      bit drop = (mode[i] != 0) && dv && (full || fl);
      if (pop)  nx[i]++;
      if (drop) nd[i]++;
      if (fl) mq[i].delete();
      else begin
        if (pop)  void'(mq[i].pop_front());
        if (push) mq[i].push_back(dd);
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    dv = v; dd = d; pr = r; fl = f;
    #1;
    check_all("cyc");
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       f;
    int         e_lv;
    logic       e_pv;
    logic [7:0] e_pd;
    logic       e_dr;
  } vec_t;

  vec_t tbl [10];
  logic [15:0] base;

  initial begin
    tbl[0] = '{1'b1, 8'd1, 1'b0, 1'b0, 1, 1'b1, 8'd1, 1'b1};
    tbl[1] = '{1'b1, 8'd2, 1'b0, 1'b0, 2, 1'b1, 8'd1, 1'b1};
    tbl[2] = '{1'b1, 8'd3, 1'b0, 1'b0, 3, 1'b1, 8'd1, 1'b1};
    tbl[3] = '{1'b1, 8'd4, 1'b0, 1'b0, 4, 1'b1, 8'd1, 1'b0};
    tbl[4] = '{1'b1, 8'd5, 1'b0, 1'b0, 4, 1'b1, 8'd1, 1'b0};
    tbl[5] = '{1'b1, 8'd5, 1'b1, 1'b0, 3, 1'b1, 8'd2, 1'b1};
    tbl[6] = '{1'b1, 8'd5, 1'b1, 1'b0, 3, 1'b1, 8'd3, 1'b1};
    tbl[7] = '{1'b0, 8'd0, 1'b1, 1'b0, 2, 1'b1, 8'd4, 1'b1};
    tbl[8] = '{1'b0, 8'd0, 1'b1, 1'b0, 1, 1'b1, 8'd5, 1'b1};
    tbl[9] = '{1'b0, 8'd0, 1'b1, 1'b0, 0, 1'b0, 8'd0, 1'b1};

    dv = 0; dd = 0; pr = 0; fl = 0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat appears one edge after the push, then drains.
    cyc(1, 8'h5A, 1, 0);
    check("single.valid", 32'(pv0), 32'd1);
    check("single.data", 32'(pd0), 32'h5A);
    check("single.level", 32'(lv0), 32'd1);
    cyc(0, 8'h00, 1, 0);
    check("single.xfer", 32'(xc0), 32'd1);
    check("single.level_after", 32'(lv0), 32'd0);

    // Fill, hold off beat 5 under backpressure, then drain 1..5.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      check($sformatf("tbl%0d.level", i), 32'(lv0), 32'(tbl[i].e_lv));
      check($sformatf("tbl%0d.valid", i), 32'(pv0), 32'(tbl[i].e_pv));
      check($sformatf("tbl%0d.data", i), 32'(pd0), 32'(tbl[i].e_pd));
      check($sformatf("tbl%0d.ready", i), 32'(dr0), 32'(tbl[i].e_dr));
    end

    // Drop mode: 9 and 10 offered while full are discarded.
    base = dc1;
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'd9, 0, 0);
    cyc(1, 8'd10, 0, 0);
    check("drop.count", 32'(dc1 - base), 32'd2);
    check("drop.mode0_zero", 32'(dc0), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drop.out%0d", i), 32'(pd1), 32'(i));
      cyc(0, 8'd0, 1, 0);
    end
    check("drop.empty", 32'(pv1), 32'd0);

    // Back-to-back streaming across pointer wrap.
    base = xc0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(i), 1, 0);
      check($sformatf("stream%0d.level", i), 32'(lv0 <= 3'd1), 32'd1);
    end
    cyc(0, 8'd0, 1, 0);
    check("stream.xfer", 32'(xc0 - base), 32'd10);

    // Flush with a simultaneous pop and push.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    check("flush.pre_level", 32'(lv0), 32'd3);
    base = xc0;
    cyc(1, 8'hEE, 1, 1);
    check("flush.level", 32'(lv0), 32'd0);
    check("flush.valid", 32'(pv0), 32'd0);
    check("flush.xfer", 32'(xc0 - base), 32'd1);
    cyc(0, 8'd0, 1, 0);
    check("flush.not_stored", 32'(pv0), 32'd0);

    // Asynchronous reset between edges with data buffered.
    cyc(1, 8'hA1, 0, 0);
    cyc(1, 8'hA2, 0, 0);
    check("areset.pre_level", 32'(lv0), 32'd2);
    dv = 0; pr = 0; fl = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h77, 1, 0);
    check("areset.fresh", 32'(pd0), 32'h77);

    // Randomized traffic with alternating drain-heavy and fill-heavy phases.
    for (int n = 0; n < 2000; n++) begin
      bit slow = ((n / 250) % 2) == 1;
      cyc($urandom_range(0, 3) != 0, 8'($urandom),
          slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          $urandom_range(0, 31) == 0);
    end
    dv = 0; pr = 0; fl = 0;
    #1 check_all("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
